// File: rtl/display_scan_bcd.sv
// Binary-to-BCD (sequential double dabble) feeding a 4-digit common-anode scanner.
// Optional macro LEADING_ZERO_BLANK_EN turns off leading-zero digits (units never blanked).
module display_scan_bcd #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dato,
    input  logic       cargar,
    output logic [3:0] bcd,
    output logic [3:0] an,
    output logic       ocupado,
    output logic       listo,
    output logic [1:0] o_dbg_state
);

    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_shift;
    logic [11:0] r_scratch;
    logic [2:0]  r_iter;
    logic [3:0]  r_d0;
    logic [3:0]  r_d1;
    logic [3:0]  r_d2;
    logic        r_ocupado;
    logic        r_listo;
    logic [PW-1:0] r_presc;
    logic [1:0]  r_sel;

    logic [11:0] w_adj;
    logic [19:0] w_dd;
    logic [19:0] w_dd_next;
    logic        w_wrap;
    logic [3:0]  w_an_raw;
    logic        w_blank;

    // One double-dabble step: correct nibbles >= 5, then shift scratch:shift left.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
        w_dd      = {w_adj, r_shift};
        w_dd_next = {w_dd[18:0], 1'b0};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cargar) w_next = S_CONV;
            S_CONV: if (r_iter == 3'd7) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            r_listo <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (cargar) begin
                        r_shift   <= dato;
                        r_scratch <= '0;
                        r_iter    <= '0;
                        r_ocupado <= 1'b1;
                    end
                end
                S_CONV: begin
                    {r_scratch, r_shift} <= w_dd_next;
                    r_iter               <= r_iter + 3'd1;
                end
                S_FIN: begin
                    r_d0      <= r_scratch[3:0];
                    r_d1      <= r_scratch[7:4];
                    r_d2      <= r_scratch[11:8];
                    r_ocupado <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Scanner runs free of the converter; a digit dwells REFRESH_DIV cycles.
    assign w_wrap = (r_presc == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_sel   <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_sel   <= r_sel + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        bcd = 4'd0;
        case (r_sel)
            2'd0: bcd = r_d0;
            2'd1: bcd = r_d1;
            2'd2: bcd = r_d2;
            default: bcd = 4'd0;
        endcase
    end

    assign w_an_raw = ~(4'b0001 << r_sel);

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        case (r_sel)
            2'd1: w_blank = (r_d1 == 4'd0) && (r_d2 == 4'd0);
            2'd2: w_blank = (r_d2 == 4'd0);
            2'd3: w_blank = 1'b1;
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    assign an          = w_blank ? 4'b1111 : w_an_raw;
    assign ocupado     = r_ocupado;
    assign listo       = r_listo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display_scan_bcd.sv
// Bench for display_scan_bcd: decimal-arithmetic reference model, per-cycle compare, literal frame checks.
module tb_display_scan_bcd;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dato = 8'd0;
    logic       cargar = 1'b0;
    logic [3:0] bcd;
    logic [3:0] an;
    logic       ocupado;
    logic       listo;
    logic [1:0] dbg_state;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    display_scan_bcd #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dato        (dato),
        .cargar      (cargar),
        .bcd         (bcd),
        .an          (an),
        .ocupado     (ocupado),
        .listo       (listo),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: a load starts a 9-edge busy window; the shown value's decimal digits are scanned.
    int m_tick  = 0;
    int m_busy  = 0;
    int m_val   = 0;
    int m_shown = 0;
    bit m_listo = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tick  <= 0;
            m_busy  <= 0;
            m_val   <= 0;
            m_shown <= 0;
            m_listo <= 1'b0;
        end else begin
            m_tick  <= (m_tick + 1) % (4 * DIV);
            m_listo <= (m_busy == 1);
            if (m_busy == 0) begin
                if (cargar) begin
                    m_busy <= 9;
                    m_val  <= int'(dato);
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_shown <= m_val;
            end
        end
    end

    function automatic int m_sel();
        return (m_tick / DIV) % 4;
    endfunction

    function automatic logic [3:0] exp_bcd();
        int p;
        p = 1;
        for (int k = 0; k < m_sel(); k++) p = p * 10;
        return 4'((m_shown / p) % 10);
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        int p;
        a = ~(4'b0001 << m_sel());
`ifdef LEADING_ZERO_BLANK_EN
        p = 1;
        for (int k = 0; k < m_sel(); k++) p = p * 10;
        if (m_sel() != 0 && m_shown < p) a = 4'b1111;
`else
        p = 0;
`endif
        return a;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an",      16'(an),      16'(exp_an()));
            chk("bcd",     16'(bcd),     16'(exp_bcd()));
            chk("ocupado", 16'(ocupado), 16'(m_busy != 0));
            chk("listo",   16'(listo),   16'(m_listo));
        end
    end

    // Drive one load, then count ocupado/listo over the following 15 sampled cycles.
    task automatic load_watch(input logic [7:0] v, output int occ, output int lis);
        occ = 0;
        lis = 0;
        @(negedge clk);
        dato   = v;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (ocupado) occ++;
            if (listo) lis++;
            @(negedge clk);
        end
    endtask

    // Literal frame: nibble s of e_bcd/e_an is what must show while digit s is selected.
    task automatic frame_lit(input string name, input logic [15:0] e_bcd, input logic [15:0] e_an);
        for (int s = 0; s < 4; s++) begin
            int guard;
            guard = 0;
            while (m_sel() != s && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) chk({name, "_timeout"}, 16'd1, 16'd0);
            chk({name, "_bcd"}, 16'(bcd), 16'(e_bcd[4*s +: 4]));
            chk({name, "_an"},  16'(an),  16'(e_an[4*s +: 4]));
        end
    endtask

    initial begin
        int occ;
        int lis;
        int cnt;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-frame.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_an",  16'(an),      16'h000E);
        chk("rst_bcd", 16'(bcd),     16'h0000);
        chk("rst_occ", 16'(ocupado), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
        chk("rst_sel_adv", 16'(an), 16'h000F);
`else
        chk("rst_sel_adv", 16'(an), 16'h000D);
`endif

        load_watch(8'd255, occ, lis);
        chk("occ_255", 16'(occ), 16'd9);
        chk("lis_255", 16'(lis), 16'd1);
`ifdef LEADING_ZERO_BLANK_EN
        frame_lit("f255", 16'h0255, 16'hFBDE);
`else
        frame_lit("f255", 16'h0255, 16'h7BDE);
`endif

        load_watch(8'd109, occ, lis);
`ifdef LEADING_ZERO_BLANK_EN
        frame_lit("f109", 16'h0109, 16'hFBDE);
`else
        frame_lit("f109", 16'h0109, 16'h7BDE);
`endif
        load_watch(8'd0, occ, lis);
`ifdef LEADING_ZERO_BLANK_EN
        frame_lit("f0", 16'h0000, 16'hFFFE);
`else
        frame_lit("f0", 16'h0000, 16'h7BDE);
`endif

        // Load of 42 arriving at E3 of the 200 conversion is ignored.
        @(negedge clk);
        dato = 8'd200;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dato = 8'd42;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (listo) cnt++;
            @(negedge clk);
        end
        chk("ign_listo", 16'(cnt), 16'd1);
`ifdef LEADING_ZERO_BLANK_EN
        frame_lit("f200", 16'h0200, 16'hFBDE);
`else
        frame_lit("f200", 16'h0200, 16'h7BDE);
`endif

        // Reset at E5 aborts the conversion.
        @(negedge clk);
        dato = 8'd77;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("e5_occ", 16'(ocupado),   16'h0000);
        chk("e5_st",  16'(dbg_state), 16'h0000);
        chk("e5_bcd", 16'(bcd),       16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (listo) cnt++;
            @(negedge clk);
        end
        chk("e5_nolisto", 16'(cnt), 16'd0);
        load_watch(8'd99, occ, lis);
        chk("occ_99", 16'(occ), 16'd9);
`ifdef LEADING_ZERO_BLANK_EN
        frame_lit("f99", 16'h0099, 16'hFFDE);
`else
        frame_lit("f99", 16'h0099, 16'h7BDE);
`endif

        // Back-to-back: cargar held for 40 edges gives four conversions.
        @(negedge clk);
        dato = 8'd17;
        cargar = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (listo) cnt++;
        end
        cargar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (listo) cnt++;
        end
        chk("b2b_listo", 16'(cnt), 16'd4);
`ifdef LEADING_ZERO_BLANK_EN
        frame_lit("f17", 16'h0017, 16'hFFDE);
`else
        frame_lit("f17", 16'h0017, 16'h7BDE);
`endif

        // Random loads with random gaps, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cargar = ($urandom_range(0, 3) == 0);
            dato   = 8'($urandom_range(0, 255));
        end
        cargar = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
